// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder between requesters A and B.
// It captures the granted operands, waits HOLD_CYCLES, then registers the sum, the signed overflow and a done pulse.

module add_circuit #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum
);
   assign o_sum = i_a + i_b + {{(WIDTH-1){1'b0}}, i_cin};
endmodule

module add_arbiter #(
   parameter int WIDTH       = 32,
   parameter int HOLD_CYCLES = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] a_opa,
   input  logic [WIDTH-1:0] a_opb,
   input  logic             req_b,
   input  logic [WIDTH-1:0] b_opa,
   input  logic [WIDTH-1:0] b_opb,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             busy
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(HOLD_CYCLES);

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_cnt, w_cnt_nxt;
   logic             r_ptr_b, w_ptr_nxt;   // 1: B wins the next tie
   logic             r_owner_b;
   logic             w_grant_a, w_grant_b, w_capture;
   logic [WIDTH-1:0] r_opa, r_opb, w_sum;
   logic             w_overflow;
   logic             r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_busy, r_overflow;
   logic [WIDTH-1:0] r_result;

   add_circuit #(.WIDTH(WIDTH)) u_add (
      .i_a   (r_opa),
      .i_b   (r_opb),
      .i_cin (1'b0),
      .o_sum (w_sum)
   );

   assign w_overflow = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_sum[WIDTH-1] != r_opa[WIDTH-1]);

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr_b;
      w_grant_a   = 1'b0;
      w_grant_b   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_a && req_b) begin
               w_grant_a = !r_ptr_b;
               w_grant_b = r_ptr_b;
               w_ptr_nxt = !r_ptr_b;
            end else begin
               w_grant_a = req_a;
               w_grant_b = req_b;
            end
            if (req_a || req_b) begin
               w_state_nxt = S_CALC;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         S_CALC: begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt <= 3'd1) begin
               w_capture   = 1'b1;
               w_state_nxt = S_OUT;
            end
         end
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: the operand latches carry no reset; they are always loaded at grant, before the adder output is used.
   always_ff @(posedge clock) begin
      if (w_grant_a || w_grant_b) begin
         r_opa <= w_grant_b ? b_opa : a_opa;
         r_opb <= w_grant_b ? b_opb : a_opb;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ptr_b    <= 1'b0;
         r_owner_b  <= 1'b0;
         r_gnt_a    <= 1'b0;
         r_gnt_b    <= 1'b0;
         r_done_a   <= 1'b0;
         r_done_b   <= 1'b0;
         r_busy     <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ptr_b  <= w_ptr_nxt;
         if (w_grant_a || w_grant_b) r_owner_b <= w_grant_b;
         r_gnt_a  <= w_grant_a;
         r_gnt_b  <= w_grant_b;
         r_done_a <= w_capture && !r_owner_b;
         r_done_b <= w_capture && r_owner_b;
         r_busy   <= (w_state_nxt != S_IDLE);
         if (w_capture) begin
            r_result   <= w_sum;
            r_overflow <= w_overflow;
         end
      end
   end

   assign gnt_a    = r_gnt_a;
   assign gnt_b    = r_gnt_b;
   assign done_a   = r_done_a;
   assign done_b   = r_done_b;
   assign busy     = r_busy;
   assign result   = r_result;
   assign overflow = r_overflow;
endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: HOLD_CYCLES=1 instance for the main flow, and a HOLD_CYCLES=3 instance for latency and mid-operation reset.
// Status vectors are packed as {gnt_a, gnt_b, done_a, done_b, busy}.

module tb_add_arbiter;
   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_a, req_b;
   logic [31:0] a_opa, a_opb, b_opa, b_opb;
   logic        gnt_a, gnt_b, done_a, done_b, overflow, busy;
   logic [31:0] result;
   logic        h3_gnt_a, h3_gnt_b, h3_done_a, h3_done_b, h3_overflow, h3_busy;
   logic [31:0] h3_result;
   logic [4:0]  flags, h3_flags;

   int n_compared   = 0;
   int n_mismatched = 0;

   assign flags    = {gnt_a, gnt_b, done_a, done_b, busy};
   assign h3_flags = {h3_gnt_a, h3_gnt_b, h3_done_a, h3_done_b, h3_busy};

   always #5 clock = ~clock;

   add_arbiter #(.WIDTH(32), .HOLD_CYCLES(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_a(req_a), .a_opa(a_opa), .a_opb(a_opb),
      .req_b(req_b), .b_opa(b_opa), .b_opb(b_opb),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
      .result(result), .overflow(overflow), .busy(busy)
   );

   add_arbiter #(.WIDTH(32), .HOLD_CYCLES(3)) dut_h3 (
      .clock(clock), .reset_n(reset_n),
      .req_a(req_a), .a_opa(a_opa), .a_opb(a_opb),
      .req_b(req_b), .b_opa(b_opa), .b_opb(b_opb),
      .gnt_a(h3_gnt_a), .gnt_b(h3_gnt_b), .done_a(h3_done_a), .done_b(h3_done_b),
      .result(h3_result), .overflow(h3_overflow), .busy(h3_busy)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req_a   = 1'b0;
      req_b   = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_a = 1'b1; a_opa = 32'h1; a_opb = 32'h2;
      req_b = 1'b1; b_opa = 32'h3; b_opb = 32'h4;
      tick();
      tick();
      n_compared++;
      if (flags !== 5'b00000) begin
         n_mismatched++; $display("FAIL reset_flags: got %b expected %b", flags, 5'b00000);
      end
      n_compared++;
      if (result !== 32'h0) begin
         n_mismatched++; $display("FAIL reset_result: got %h expected %h", result, 32'h0);
      end
      n_compared++;
      if (overflow !== 1'b0) begin
         n_mismatched++; $display("FAIL reset_overflow: got %b expected 0", overflow);
      end
      n_compared++;
      if ({h3_flags, h3_overflow} !== 6'b0) begin
         n_mismatched++; $display("FAIL reset_h3_flags: got %b expected %b", {h3_flags, h3_overflow}, 6'b0);
      end
      n_compared++;
      if (h3_result !== 32'h0) begin
         n_mismatched++; $display("FAIL reset_h3_result: got %h expected %h", h3_result, 32'h0);
      end
      req_a   = 1'b0;
      req_b   = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      a_opa = 32'd5; a_opb = 32'd7; req_a = 1'b1;
      tick();
      n_compared++;
      if (flags !== 5'b10001) begin
         n_mismatched++; $display("FAIL single_gnt: got %b expected %b", flags, 5'b10001);
      end
      req_a = 1'b0;
      tick();
      n_compared++;
      if (flags !== 5'b00101) begin
         n_mismatched++; $display("FAIL single_done: got %b expected %b", flags, 5'b00101);
      end
      n_compared++;
      if ({result, overflow} !== {32'h0000000C, 1'b0}) begin
         n_mismatched++; $display("FAIL single_result: got %h/%b expected 0000000c/0", result, overflow);
      end
      tick();
      n_compared++;
      if (flags !== 5'b00000) begin
         n_mismatched++; $display("FAIL single_idle: got %b expected %b", flags, 5'b00000);
      end
      n_compared++;
      if (result !== 32'h0000000C) begin
         n_mismatched++; $display("FAIL single_hold: got %h expected 0000000c", result);
      end
   endtask

   task automatic test_contention();
      logic [31:0] va [2] = '{32'd1, 32'd10};
      logic [31:0] vb [2] = '{32'd2, 32'd20};
      logic [31:0] wa [2] = '{32'd3, 32'h100};
      logic [31:0] wb [2] = '{32'd4, 32'h200};
      logic [31:0] ra [2] = '{32'h3, 32'h1E};
      logic [31:0] rb [2] = '{32'h7, 32'h300};
      logic        b_first;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         b_first = (r == 1);
         a_opa = va[r]; a_opb = vb[r]; b_opa = wa[r]; b_opb = wb[r];
         req_a = 1'b1; req_b = 1'b1;
         for (int k = 0; k < 2; k++) begin
            logic       serve_b;
            logic [4:0] exp_g, exp_d;
            logic [31:0] exp_r;
            serve_b = (k == 0) ? b_first : !b_first;
            exp_g   = serve_b ? 5'b01001 : 5'b10001;
            exp_d   = serve_b ? 5'b00011 : 5'b00101;
            exp_r   = serve_b ? rb[r] : ra[r];
            tick();
            n_compared++;
            if (flags !== exp_g) begin
               n_mismatched++; $display("FAIL cont_gnt r%0d k%0d: got %b expected %b", r, k, flags, exp_g);
            end
            if (serve_b) req_b = 1'b0; else req_a = 1'b0;
            tick();
            n_compared++;
            if (flags !== exp_d) begin
               n_mismatched++; $display("FAIL cont_done r%0d k%0d: got %b expected %b", r, k, flags, exp_d);
            end
            n_compared++;
            if (result !== exp_r) begin
               n_mismatched++; $display("FAIL cont_result r%0d k%0d: got %h expected %h", r, k, result, exp_r);
            end
            tick();
            n_compared++;
            if (flags !== 5'b00000) begin
               n_mismatched++; $display("FAIL cont_idle r%0d k%0d: got %b expected %b", r, k, flags, 5'b00000);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] va [3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      logic [31:0] vb [3] = '{32'h00000001, 32'h00000001, 32'h80000000};
      logic [31:0] vr [3] = '{32'h80000000, 32'h00000000, 32'h00000000};
      logic        vo [3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         a_opa = va[i]; a_opb = vb[i]; req_a = 1'b1;
         tick();
         req_a = 1'b0;
         tick();
         n_compared++;
         if (flags !== 5'b00101) begin
            n_mismatched++; $display("FAIL ovf_done %0d: got %b expected %b", i, flags, 5'b00101);
         end
         n_compared++;
         if ({result, overflow} !== {vr[i], vo[i]}) begin
            n_mismatched++; $display("FAIL ovf_result %0d: got %h/%b expected %h/%b", i, result, overflow, vr[i], vo[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      a_opa = 32'd100; a_opb = 32'd23; req_a = 1'b1;
      tick();
      n_compared++;
      if (flags !== 5'b10001) begin
         n_mismatched++; $display("FAIL b2b_gnt1: got %b expected %b", flags, 5'b10001);
      end
      a_opa = 32'h1000; a_opb = 32'h0234;
      tick();
      n_compared++;
      if ({flags, result} !== {5'b00101, 32'h7B}) begin
         n_mismatched++; $display("FAIL b2b_done1: got %b/%h expected 00101/0000007b", flags, result);
      end
      tick();
      n_compared++;
      if (flags !== 5'b00000) begin
         n_mismatched++; $display("FAIL b2b_idle: got %b expected %b", flags, 5'b00000);
      end
      tick();
      n_compared++;
      if (flags !== 5'b10001) begin
         n_mismatched++; $display("FAIL b2b_gnt2: got %b expected %b", flags, 5'b10001);
      end
      req_a = 1'b0;
      tick();
      n_compared++;
      if ({flags, result} !== {5'b00101, 32'h1234}) begin
         n_mismatched++; $display("FAIL b2b_done2: got %b/%h expected 00101/00001234", flags, result);
      end
      tick();
   endtask

   task automatic test_operand_stability();
      for (int i = 0; i <= 30; i++) begin
         logic        use_b;
         logic [31:0] op, exp_r;
         logic [4:0]  exp_g, exp_d;
         use_b = (i % 2 == 1);
         op    = 32'h1 << i;
         exp_r = 32'h1 << (i + 1);
         exp_g = use_b ? 5'b01001 : 5'b10001;
         exp_d = use_b ? 5'b00011 : 5'b00101;
         if (use_b) begin b_opa = op; b_opb = op; req_b = 1'b1; end
         else begin a_opa = op; a_opb = op; req_a = 1'b1; end
         tick();
         n_compared++;
         if (flags !== exp_g) begin
            n_mismatched++; $display("FAIL stab_gnt %0d: got %b expected %b", i, flags, exp_g);
         end
         req_a = 1'b0; req_b = 1'b0;
         a_opa = 32'hDEADBEEF; a_opb = 32'h0BADF00D;
         b_opa = 32'hCAFEF00D; b_opb = 32'h12345678;
         tick();
         n_compared++;
         if ({flags, result, overflow} !== {exp_d, exp_r, (i == 30)}) begin
            n_mismatched++;
            $display("FAIL stab_result %0d: got %b/%h/%b expected %b/%h/%b", i, flags, result, overflow, exp_d, exp_r, (i == 30));
         end
         tick();
      end
   endtask

   task automatic test_midop_reset();
      logic [4:0] exp_h3 [5] = '{5'b01001, 5'b00001, 5'b00001, 5'b00011, 5'b00000};
      do_reset();
      b_opa = 32'h11111111; b_opb = 32'h22222222; req_b = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         req_b = 1'b0;
         n_compared++;
         if (h3_flags !== exp_h3[c]) begin
            n_mismatched++; $display("FAIL h3_seq c%0d: got %b expected %b", c + 1, h3_flags, exp_h3[c]);
         end
      end
      n_compared++;
      if (h3_result !== 32'h33333333) begin
         n_mismatched++; $display("FAIL h3_result: got %h expected 33333333", h3_result);
      end
      b_opa = 32'h5; b_opb = 32'h6; req_b = 1'b1;
      tick();
      req_b = 1'b0;
      n_compared++;
      if (h3_flags !== 5'b01001) begin
         n_mismatched++; $display("FAIL midrst_gnt: got %b expected %b", h3_flags, 5'b01001);
      end
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         n_compared++;
         if ({h3_flags, h3_result, h3_overflow} !== {5'b00000, 32'h0, 1'b0}) begin
            n_mismatched++; $display("FAIL midrst_after c%0d: got %b/%h/%b expected 00000/00000000/0", c, h3_flags, h3_result, h3_overflow);
         end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_overflow();
      test_back_to_back();
      test_operand_stability();
      test_midop_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
